pwm_from_div: RTL and testbench

// - Downstream consumer of ClkDivider's clk_div output; turns it into a fixed-period PWM waveform.
// - Rising edges of clk_div are detected in the clk domain and used as single-cycle ticks. clk_div is never used as a clock.
// - Duty cycle is loaded through a valid/ready handshake and applied only at period boundaries, so pulses are glitch-free.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/edge_rise.sv | 33 +++
 rtl/pwm_from_div.sv | 109 ++++++++++
 tb/tb_pwm_from_div.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM-from-divided-clock block.
// - cnt_width(): width of the tick counter and duty values for a given period
// - SAT_DUTY_ON_ACCEPT: duty requests above the period are clamped to the period
package pwm_pkg;

   localparam bit SAT_DUTY_ON_ACCEPT = 1'b1;

   // Enough bits to hold 0..period inclusive, since duty == period means always high.
   function automatic int cnt_width(input int period);
      return $clog2(period + 1);
   endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a level that already lives in the clk domain.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   d     in   level to watch
//   pulse out  high in the first cycle d is sampled high (combinational)
// The history flop resets to 1 so a level that is already high when reset
// releases is not mistaken for a fresh edge.
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic d_q;
   logic d_d;

   always_comb begin
      d_d = d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= 1'b1;
      end else begin
         d_q <= d_d;
      end
   end

   assign pulse = d & ~d_q;

endmodule

// File: rtl/pwm_from_div.sv
// Fixed-period PWM driven by rising edges of a divided-clock level.
// clk_div is only sampled, never used as a clock; each rising edge becomes a
// one-cycle tick that advances the period counter. Duty values arrive through
// a single-entry valid/ready slot and take effect only at a period wrap.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   clk_div      in   divided-clock level (clk domain)
//   duty_in      in   requested high-time in ticks, clamped to PERIOD
//   duty_valid   in   duty_in offered
//   duty_ready   out  slot free; transfer on duty_valid && duty_ready
//   pwm_out      out  registered PWM waveform
//   period_done  out  one-cycle pulse when the counter wraps
//   tick_out     out  registered copy of the internal tick
module pwm_from_div
   import pwm_pkg::*;
#(
   parameter int PERIOD = 100,
   parameter int CNT_W  = cnt_width(PERIOD)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_div,
   input  logic [CNT_W-1:0] duty_in,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_out,
   output logic             period_done,
   output logic             tick_out
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] MAX_DUTY = CNT_W'(PERIOD);

   logic             tick;
   logic             wrap;
   logic             accept;

   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic [CNT_W-1:0] duty_act_q,    duty_act_d;
   logic [CNT_W-1:0] pend_duty_q,   pend_duty_d;
   logic             pend_vld_q,    pend_vld_d;
   logic             pwm_q,         pwm_d;
   logic             period_done_q, period_done_d;
   logic             tick_q,        tick_d;

   edge_rise u_div_edge (
      .clk   (clk),
      .rst   (rst),
      .d     (clk_div),
      .pulse (tick)
   );

   assign wrap   = tick && (cnt_q == LAST_CNT);
   assign accept = duty_valid && !pend_vld_q;

   always_comb begin
      cnt_d         = cnt_q;
      duty_act_d    = duty_act_q;
      pend_duty_d   = pend_duty_q;
      pend_vld_d    = pend_vld_q;
      period_done_d = wrap;
      tick_d        = tick;
      // Uses the pre-update counter and duty, so the output lags cnt by one clk.
      pwm_d         = (cnt_q < duty_act_q);

      if (tick) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end

      if (wrap && pend_vld_q) begin
         duty_act_d = pend_duty_q;
         pend_vld_d = 1'b0;
      end

      // accept needs an empty slot, so it never collides with the wrap load
      // above; a value taken on a wrap tick waits for the next wrap.
      if (accept) begin
         pend_vld_d  = 1'b1;
         pend_duty_d = (SAT_DUTY_ON_ACCEPT && (duty_in > MAX_DUTY)) ? MAX_DUTY : duty_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         duty_act_q    <= '0;
         pend_duty_q   <= '0;
         pend_vld_q    <= 1'b0;
         pwm_q         <= 1'b0;
         period_done_q <= 1'b0;
         tick_q        <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         duty_act_q    <= duty_act_d;
         pend_duty_q   <= pend_duty_d;
         pend_vld_q    <= pend_vld_d;
         pwm_q         <= pwm_d;
         period_done_q <= period_done_d;
         tick_q        <= tick_d;
      end
   end

   assign duty_ready  = ~pend_vld_q;
   assign pwm_out     = pwm_q;
   assign period_done = period_done_q;
   assign tick_out    = tick_q;

endmodule

// File: tb/tb_pwm_from_div.sv
module tb_pwm_from_div;

   localparam int PERIOD   = 4;
   localparam int CNT_W    = 3;
   localparam int DIV_HALF = 5;   // clk_div period = 10 clk

   logic             clk = 1'b0;
   logic             rst;
   logic             clk_div;
   logic [CNT_W-1:0] duty_in;
   logic             duty_valid;
   logic             duty_ready;
   logic             pwm_out;
   logic             period_done;
   logic             tick_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pwm_from_div #(.PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_div     (clk_div),
      .duty_in     (duty_in),
      .duty_valid  (duty_valid),
      .duty_ready  (duty_ready),
      .pwm_out     (pwm_out),
      .period_done (period_done),
      .tick_out    (tick_out)
   );

   // Upstream divider stand-in: toggles every DIV_HALF clocks, or holds div_level.
   logic div_run   = 1'b0;
   logic div_level = 1'b1;
   int   div_cnt   = 0;
   always @(posedge clk) begin
      #1;
      if (!div_run) begin
         div_cnt = 0;
         clk_div = div_level;
      end else if (div_cnt == DIV_HALF - 1) begin
         div_cnt = 0;
         clk_div = ~clk_div;
      end else begin
         div_cnt++;
      end
   end

   // Reference model: phase within period, active duty, queue of pending duties.
   int   m_phase = 0;
   int   m_duty  = 0;
   int   m_rises = 0;
   int   m_pend[$];
   logic m_prev  = 1'b1;
   logic m_rise;
   logic m_acc;
   logic exp_pwm = 1'b0, exp_pd = 1'b0, exp_tick = 1'b0, exp_ready = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         m_prev    = 1'b1;
         m_phase   = 0;
         m_duty    = 0;
         m_pend.delete();
         exp_pwm   = 1'b0;
         exp_pd    = 1'b0;
         exp_tick  = 1'b0;
         exp_ready = 1'b1;
      end else begin
         m_rise   = (clk_div === 1'b1) && !m_prev;
         m_prev   = (clk_div === 1'b1);
         m_acc    = (duty_valid === 1'b1) && (m_pend.size() == 0);
         exp_pwm  = (m_phase < m_duty);
         exp_tick = m_rise;
         exp_pd   = 1'b0;
         if (m_rise) begin
            m_rises++;
            if (m_phase == PERIOD - 1) begin
               m_phase = 0;
               exp_pd  = 1'b1;
               if (m_pend.size() > 0) m_duty = m_pend.pop_front();
            end else begin
               m_phase++;
            end
         end
         if (m_acc) m_pend.push_back((int'(duty_in) > PERIOD) ? PERIOD : int'(duty_in));
         exp_ready = (m_pend.size() == 0);
      end
   end

   // Continuous model comparison plus period-spacing and tick scoreboards.
   logic chk_en      = 1'b0;
   int   ticks_since = 0;
   int   dut_ticks   = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (pwm_out !== exp_pwm) begin
            bad++;
            $display("FAIL model_pwm t=%0t got=%b exp=%b", $time, pwm_out, exp_pwm);
         end
         total++;
         if (period_done !== exp_pd) begin
            bad++;
            $display("FAIL model_period_done t=%0t got=%b exp=%b", $time, period_done, exp_pd);
         end
         total++;
         if (tick_out !== exp_tick) begin
            bad++;
            $display("FAIL model_tick t=%0t got=%b exp=%b", $time, tick_out, exp_tick);
         end
         total++;
         if (duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL model_ready t=%0t got=%b exp=%b", $time, duty_ready, exp_ready);
         end
         if (tick_out === 1'b1) dut_ticks++;
         if (rst === 1'b1) begin
            ticks_since = 0;
         end else begin
            if (tick_out === 1'b1) ticks_since++;
            if (period_done === 1'b1) begin
               total++;
               if (ticks_since != PERIOD) begin
                  bad++;
                  $display("FAIL period_spacing t=%0t got=%0d exp=%0d", $time, ticks_since, PERIOD);
               end
               ticks_since = 0;
            end
         end
      end
   end

   task automatic wait_wrap(output int hi, output int rdy_lo);
      bit got;
      got    = 1'b0;
      hi     = 0;
      rdy_lo = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (pwm_out === 1'b1) hi++;
         if (duty_ready === 1'b0) rdy_lo++;
         if (period_done === 1'b1) got = 1'b1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL wrap_timeout t=%0t got=none exp=period_done", $time);
      end
   endtask

   task automatic offer(input int d);
      @(posedge clk);
      #1 duty_valid = 1'b1;
      duty_in = CNT_W'(d);
      @(posedge clk);
      #1 duty_valid = 1'b0;
   endtask

   task automatic test_reset();
      int tcnt;
      bit got;
      tcnt = 0;
      got  = 1'b0;
      rst = 1'b1; div_run = 1'b0; div_level = 1'b1; duty_valid = 1'b0; duty_in = '0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (19) @(posedge clk);
      @(negedge clk);
      total++;
      if (duty_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", duty_ready); end
      total++;
      if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
      total++;
      if (tick_out !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick_out); end
      total++;
      if (period_done !== 1'b0) begin bad++; $display("FAIL reset_period_done got=%b exp=0", period_done); end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (tick_out === 1'b1) tcnt++;
      end
      total++;
      if (tcnt != 0) begin bad++; $display("FAIL held_high_tick got=%0d exp=0", tcnt); end
      div_run = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (tick_out === 1'b1) got = 1'b1;
      end
      total++;
      if (!got) begin bad++; $display("FAIL first_tick got=none exp=tick"); end
      total++;
      if (pwm_out !== 1'b0) begin bad++; $display("FAIL idle_pwm got=%b exp=0", pwm_out); end
   endtask

   task automatic test_duty1();
      int hi, rl;
      offer(1);
      @(negedge clk);
      total++;
      if (duty_ready !== 1'b0) begin bad++; $display("FAIL load_ready_low got=%b exp=0", duty_ready); end
      wait_wrap(hi, rl);
      total++;
      if (duty_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready_high got=%b exp=1", duty_ready); end
      wait_wrap(hi, rl);
      total++;
      if (hi != 10) begin bad++; $display("FAIL duty1_high got=%0d exp=10", hi); end
   endtask

   task automatic test_duty0_then_4();
      int hi, rl;
      offer(0);
      wait_wrap(hi, rl);
      offer(4);
      wait_wrap(hi, rl);
      total++;
      if (hi != 0) begin bad++; $display("FAIL duty0_high got=%0d exp=0", hi); end
      wait_wrap(hi, rl);
      total++;
      if (hi != 40) begin bad++; $display("FAIL duty4_first got=%0d exp=40", hi); end
      wait_wrap(hi, rl);
      total++;
      if (hi != 40) begin bad++; $display("FAIL duty4_across_wrap got=%0d exp=40", hi); end
   endtask

   task automatic test_wrap_accept();
      int hi, rl;
      repeat (39) @(posedge clk);
      #1 duty_valid = 1'b1;
      duty_in = 3'd3;
      @(posedge clk);
      #1 duty_valid = 1'b0;
      @(negedge clk);
      total++;
      if (period_done !== 1'b1) begin bad++; $display("FAIL wrap_align got=%b exp=1", period_done); end
      total++;
      if (duty_ready !== 1'b0) begin bad++; $display("FAIL wrap_accept_slot got=%b exp=0", duty_ready); end
      wait_wrap(hi, rl);
      total++;
      if (hi != 40) begin bad++; $display("FAIL old_duty_held got=%0d exp=40", hi); end
      wait_wrap(hi, rl);
      total++;
      if (hi != 30) begin bad++; $display("FAIL duty3_applied got=%0d exp=30", hi); end
   endtask

   task automatic test_saturate();
      int hi, rl;
      @(posedge clk);
      #1 duty_valid = 1'b1;
      duty_in = 3'd7;
      @(posedge clk);
      #1 duty_in = 3'd2;
      wait_wrap(hi, rl);
      total++;
      if (hi != 29) begin bad++; $display("FAIL stall_period_high got=%0d exp=29", hi); end
      total++;
      if (rl != 38) begin bad++; $display("FAIL stall_ready_low got=%0d exp=38", rl); end
      total++;
      if (duty_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", duty_ready); end
      @(posedge clk);
      #1 duty_valid = 1'b0;
      @(negedge clk);
      total++;
      if (duty_ready !== 1'b0) begin bad++; $display("FAIL second_accept got=%b exp=0", duty_ready); end
      wait_wrap(hi, rl);
      total++;
      if (hi != 39) begin bad++; $display("FAIL saturated_high got=%0d exp=39", hi); end
      wait_wrap(hi, rl);
      total++;
      if (hi != 20) begin bad++; $display("FAIL duty2_after_stall got=%0d exp=20", hi); end
   endtask

   task automatic test_reset_mid();
      int hi, rl;
      offer(1);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (duty_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", duty_ready); end
      total++;
      if (pwm_out !== 1'b0) begin bad++; $display("FAIL midrst_pwm got=%b exp=0", pwm_out); end
      total++;
      if (period_done !== 1'b0) begin bad++; $display("FAIL midrst_period_done got=%b exp=0", period_done); end
      @(posedge clk);
      #1 rst = 1'b0;
      wait_wrap(hi, rl);
      total++;
      if (hi != 0) begin bad++; $display("FAIL midrst_first_period got=%0d exp=0", hi); end
      wait_wrap(hi, rl);
      total++;
      if (hi != 0) begin bad++; $display("FAIL midrst_pending_dropped got=%0d exp=0", hi); end
      offer(2);
      wait_wrap(hi, rl);
      wait_wrap(hi, rl);
      total++;
      if (hi != 20) begin bad++; $display("FAIL midrst_reload got=%0d exp=20", hi); end
   endtask

   task automatic test_random();
      bit got, acc;
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 50)) @(posedge clk);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1 div_level = 1'b1;
            div_run = 1'b0;
            repeat ($urandom_range(10, 40)) @(posedge clk);
            #1 div_run = 1'b1;
         end
         @(posedge clk);
         #1 duty_valid = 1'b1;
         duty_in = CNT_W'($urandom_range(0, 7));
         got = 1'b0;
         for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            acc = (duty_ready === 1'b1);
            @(posedge clk);
            #1;
            if (acc) got = 1'b1;
         end
         duty_valid = 1'b0;
         if (!got) begin
            total++;
            bad++;
            $display("FAIL random_accept_timeout n=%0d got=stalled exp=accept", n);
         end
      end
      repeat (100) @(posedge clk);
   endtask

   task automatic test_tick_count();
      @(negedge clk);
      total++;
      if (dut_ticks != m_rises) begin
         bad++;
         $display("FAIL tick_count got=%0d exp=%0d", dut_ticks, m_rises);
      end
   endtask

   initial begin
      rst        = 1'b1;
      duty_valid = 1'b0;
      duty_in    = '0;
      test_reset();
      test_duty1();
      test_duty0_then_4();
      test_wrap_accept();
      test_saturate();
      test_reset_mid();
      test_random();
      test_tick_count();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog t=%0t got=running exp=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
